dmux_nch_router: RTL and testbench
==================================

// Module: dmux_nch_router
// PURPOSE
//  Next-generation data demultiplexer: single-clock, NUM_CH output channels, valid/ready on every side.
//  Routes each accepted input word to the channel named by data_in_sel.
//  Each channel buffers words in its own FIFO_DEPTH-entry FIFO, so a stalled channel does not block the others.
//  Sits between the upstream data source and NUM_CH downstream consumers.
// PARAMETERS
//  DATA_WIDTH  39  width of one data word
//  NUM_CH      4   number of output channels, 2..16
//  FIFO_DEPTH  2   entries per channel FIFO; power of 2, >=2
//  CNT_W       8   width of the saturating drop counter
// PORTS
//  clk_i         in   1                   single clock; all logic on posedge
//  reset         in   1                   asynchronous, active-high reset
//  data_in       in   DATA_WIDTH          input word
//  data_in_sel   in   SEL_W=$clog2(NUM_CH) destination channel of data_in
//  data_in_vld   in   1                   input word valid
//  data_in_rdy   out  1                   router can accept data_in this cycle
//  data_out      out  NUM_CH*DATA_WIDTH   channel c word at [c*DATA_WIDTH +: DATA_WIDTH]
//  data_out_vld  out  NUM_CH              per-channel valid (FIFO non-empty)
//  data_out_rdy  in   NUM_CH              per-channel consumer ready
//  err_bad_sel   out  1                   1-cycle pulse: a word with data_in_sel >= NUM_CH was dropped
//  drop_cnt      out  CNT_W               saturating count of dropped words
// BEHAVIOUR
//  - Reset: all FIFOs empty; data_out_vld=0, data_out=0, err_bad_sel=0, drop_cnt=0.
//    data_in_rdy=0 while reset is high.
//  - Accept: data_in_vld && data_in_rdy at a rising edge.
//  - data_in_rdy (combinational from data_in_sel and FIFO state):
//    - sel < NUM_CH: data_in_rdy = !full[sel].
//    - sel >= NUM_CH: data_in_rdy = 1. The word is accepted, discarded, err_bad_sel is pulsed next cycle, and drop_cnt increments, saturating at 2**CNT_W-1.
//  - Pop: channel c pops when data_out_vld[c] && data_out_rdy[c]. Channels are fully independent.
//  - Latency: a word accepted in cycle N into an empty FIFO shows data_out_vld=1 in cycle N+1.
//  - No combinational input-to-output bypass.
//  - data_out[c] always equals the FIFO head.
//    It is held stable while data_out_vld[c]=1 and data_out_rdy[c]=0.
//  - Ordering: FIFO order is preserved per channel. There is no ordering between channels.
//  - Full FIFO with pop in the same cycle: data_in_rdy stays 0 for that channel in that cycle (no pass-through on full).
//    Push is possible from the next cycle.
//  - Empty FIFO: no pop occurs; data_out_vld stays 0.
//  - Push and pop to a non-full, non-empty FIFO in the same cycle: occupancy is unchanged.
//  - Pointers: log2(FIFO_DEPTH) bits plus a wrap bit. full = same index, wrap bits differ.
//    Wrap-around is seamless.
//  - Reset asserted mid-operation: all buffered words are discarded immediately (async).
//    drop_cnt clears. Outputs go to reset values in the same instant.
//  - data_in_vld=0: data_in and data_in_sel are ignored.
// STRUCTURE
//  - Package dmux_pkg:
//    - function sel_w(NUM_CH) returning $clog2(NUM_CH), minimum 1.
//    - DMUX_DATA_WIDTH_DEF = 39.
//    - typedef dmux_cnt_t for the drop counter.
//  - Sub-module dmux_ch_fifo (DATA_WIDTH, FIFO_DEPTH), one instance per channel via generate.
//    - Inputs: push, push_data, pop.
//    - Outputs: head, empty, full.
//  - Top level:
//    - one-hot decode of data_in_sel
//    - data_in_rdy mux
//    - bad-select detect, err_bad_sel flop, drop counter
// TESTING
//  1. Reset, then idle: all data_out_vld=0, data_in_rdy=1, drop_cnt=0. Async reset asserted between edges clears outputs at once.
//  2. Push 39'h3456 to ch2 at cycle N with all rdy=1 -> data_out_vld=4'b0100 at N+1, data_out[2]=39'h3456, popped at N+1.
//  3. Hold data_out_rdy[1]=0 and push 3 words to ch1 (DEPTH=2) -> 3rd word sees data_in_rdy=0.
//     Raise rdy[1] -> words 1,2,3 appear in order; word 3 is accepted only after the first pop.
//  4. Interleave ch0 and ch3 pushes with ch3 stalled -> ch0 words drain without stalls; ch3 stays full.
//  5. NUM_CH=3, sel=3 -> accepted, err_bad_sel pulses one cycle, drop_cnt 0->1.
//     With CNT_W=2, 5 bad words -> drop_cnt=3 (saturated).
//  6. Reset asserted with 2 words held in ch0 -> data_out_vld[0]=0. After release, push 39'h1 to ch0 -> only 39'h1 emerges.

Source files
------------

// File: rtl/dmux_pkg.sv
// Shared types, defaults and helpers for the N-channel data demultiplexer.
package dmux_pkg;

  localparam int DMUX_DATA_WIDTH_DEF = 39;
  localparam int DMUX_CNT_W_DEF      = 8;

  typedef logic [DMUX_CNT_W_DEF-1:0] dmux_cnt_t;

  // Select width for a channel count; never narrower than one bit.
  function automatic int sel_w(input int num_ch);
    int w;
    w = $clog2(num_ch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmux_ch_fifo.sv
// Per-channel FIFO: a push becomes visible at the head next cycle; no push while full.
// The head reads as zero while the FIFO is empty, so idle channels present a clean bus.
module dmux_ch_fifo #(
  parameter int DATA_WIDTH = 39,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_q, wr_d;
  logic [AW:0]           rd_q, rd_d;
  logic                  do_push, do_pop;

  // Extra MSB is the wrap bit: equal indices with differing wrap bits means full.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dmux_nch_router.sv
// Routes each accepted word into the FIFO of the channel named by data_in_sel; one-cycle latency.
// data_in_rdy drops only when the addressed FIFO is full; out-of-range selects are always taken and dropped.
module dmux_nch_router
  import dmux_pkg::*;
#(
  parameter  int DATA_WIDTH = DMUX_DATA_WIDTH_DEF,
  parameter  int NUM_CH     = 4,
  parameter  int FIFO_DEPTH = 2,
  parameter  int CNT_W      = DMUX_CNT_W_DEF,
  localparam int SEL_W      = sel_w(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [SEL_W-1:0]             data_in_sel,
  input  logic                         data_in_vld,
  output logic                         data_in_rdy,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            data_out_vld,
  input  logic [NUM_CH-1:0]            data_out_rdy,
  output logic                         err_bad_sel,
  output logic [CNT_W-1:0]             drop_cnt
);

  logic [NUM_CH-1:0]     sel_oh, full, empty, push, pop;
  logic [DATA_WIDTH-1:0] head [NUM_CH];
  logic                  bad_sel, accept, drop;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    sel_oh = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (data_in_sel == SEL_W'(c)) sel_oh[c] = 1'b1;
    end
  end

  // No decoded channel means the select is out of range.
  assign bad_sel     = ~|sel_oh;
  assign data_in_rdy = ~reset & (bad_sel | |(sel_oh & ~full));
  assign accept      = data_in_vld & data_in_rdy;
  assign push        = {NUM_CH{accept}} & sel_oh;
  assign drop        = accept & bad_sel;
  assign pop         = data_out_vld & data_out_rdy;

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    dmux_ch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .reset       (reset),
      .push_i      (push[c]),
      .push_data_i (data_in),
      .pop_i       (pop[c]),
      .head_o      (head[c]),
      .empty_o     (empty[c]),
      .full_o      (full[c])
    );
    assign data_out[c*DATA_WIDTH +: DATA_WIDTH] = head[c];
    assign data_out_vld[c]                      = ~empty[c];
  end

  always_comb begin
    err_d = drop;
    cnt_d = cnt_q;
    if (drop && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_bad_sel = err_q;
  assign drop_cnt    = cnt_q;

endmodule

// File: tb/tb_dmux_nch_router.sv
// Directed bench: a 4-channel router for routing/backpressure and a 3-channel, 2-bit-counter router for drops.
module tb_dmux_nch_router;

  localparam int DW = 39;

  logic          clk = 1'b0;
  logic          reset;

  logic [DW-1:0] a_in;
  logic [1:0]    a_sel;
  logic          a_vld, a_rdy;
  logic [4*DW-1:0] a_out;
  logic [3:0]    a_out_vld, a_out_rdy;
  logic          a_err;
  logic [7:0]    a_drop;

  logic [DW-1:0] b_in;
  logic [1:0]    b_sel;
  logic          b_vld, b_rdy;
  logic [3*DW-1:0] b_out;
  logic [2:0]    b_out_vld, b_out_rdy;
  logic          b_err;
  logic [1:0]    b_drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmux_nch_router #(.DATA_WIDTH(DW), .NUM_CH(4), .FIFO_DEPTH(2), .CNT_W(8)) u_a (
    .clk_i(clk), .reset(reset),
    .data_in(a_in), .data_in_sel(a_sel), .data_in_vld(a_vld), .data_in_rdy(a_rdy),
    .data_out(a_out), .data_out_vld(a_out_vld), .data_out_rdy(a_out_rdy),
    .err_bad_sel(a_err), .drop_cnt(a_drop)
  );

  dmux_nch_router #(.DATA_WIDTH(DW), .NUM_CH(3), .FIFO_DEPTH(2), .CNT_W(2)) u_b (
    .clk_i(clk), .reset(reset),
    .data_in(b_in), .data_in_sel(b_sel), .data_in_vld(b_vld), .data_in_rdy(b_rdy),
    .data_out(b_out), .data_out_vld(b_out_vld), .data_out_rdy(b_out_rdy),
    .err_bad_sel(b_err), .drop_cnt(b_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] a_ch(input int c);
    return a_out[c*DW +: DW];
  endfunction

  initial begin
    reset = 1'b1;
    a_in = '0; a_sel = '0; a_vld = 1'b0; a_out_rdy = 4'b1111;
    b_in = '0; b_sel = '0; b_vld = 1'b0; b_out_rdy = 3'b111;

    // 1. reset state and idle
    #12;
    chk("rst_rdy", 64'(a_rdy), 64'd0);
    chk("rst_vld", 64'(a_out_vld), 64'd0);
    chk("rst_out", 64'(a_out[63:0]), 64'd0);
    chk("rst_drop", 64'(a_drop), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_rdy", 64'(a_rdy), 64'd1);
    chk("idle_vld", 64'(a_out_vld), 64'd0);

    // 2. single word to ch2
    a_in = 39'h3456; a_sel = 2'd2; a_vld = 1'b1;
    #1 chk("t2_rdy", 64'(a_rdy), 64'd1);
    tick();
    a_vld = 1'b0;
    chk("t2_vld", 64'(a_out_vld), 64'b0100);
    chk("t2_dat", 64'(a_ch(2)), 64'h3456);
    tick();
    chk("t2_pop", 64'(a_out_vld), 64'd0);

    // 3. ch1 backpressure, depth 2
    a_out_rdy = 4'b1101;
    a_in = 39'h11; a_sel = 2'd1; a_vld = 1'b1;
    tick();
    a_in = 39'h12;
    tick();
    a_in = 39'h13;
    #1 chk("t3_full_rdy", 64'(a_rdy), 64'd0);
    tick();
    chk("t3_head1", 64'(a_ch(1)), 64'h11);
    chk("t3_still_full", 64'(a_rdy), 64'd0);
    a_out_rdy = 4'b1111;
    #1 chk("t3_no_passthru", 64'(a_rdy), 64'd0);
    tick();
    chk("t3_head2", 64'(a_ch(1)), 64'h12);
    chk("t3_rdy_after_pop", 64'(a_rdy), 64'd1);
    tick();
    a_vld = 1'b0;
    chk("t3_head3", 64'(a_ch(1)), 64'h13);
    tick();
    chk("t3_empty", 64'(a_out_vld), 64'd0);

    // 4. ch0/ch3 interleave, ch3 stalled
    a_out_rdy = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        chk("t4_ch0_vld", 64'(a_out_vld[0]), 64'd1);
        chk("t4_ch0_dat", 64'(a_ch(0)), 64'(39'hA0 + 39'(i / 2)));
      end else if (i > 0) begin
        chk("t4_ch0_drained", 64'(a_out_vld[0]), 64'd0);
      end
      a_sel = (i % 2 == 1) ? 2'd3 : 2'd0;
      a_in  = (i % 2 == 1) ? 39'hB0 + 39'(i / 2) : 39'hA0 + 39'(i / 2);
      a_vld = 1'b1;
      #1 chk("t4_rdy", 64'(a_rdy), (i == 5) ? 64'd0 : 64'd1);
      tick();
    end
    a_vld = 1'b0;
    tick();
    chk("t4_vld", 64'(a_out_vld), 64'b1000);
    chk("t4_ch3_hold", 64'(a_ch(3)), 64'hB0);
    a_out_rdy = 4'b1111;
    tick();
    chk("t4_ch3_second", 64'(a_ch(3)), 64'hB1);
    tick();
    chk("t4_ch3_empty", 64'(a_out_vld), 64'd0);

    // 5. bad select on the 3-channel router, 2-bit saturating counter
    b_sel = 2'd3; b_in = 39'h55; b_vld = 1'b1;
    #1 chk("t5_rdy", 64'(b_rdy), 64'd1);
    tick();
    b_vld = 1'b0;
    chk("t5_err", 64'(b_err), 64'd1);
    chk("t5_drop1", 64'(b_drop), 64'd1);
    chk("t5_no_vld", 64'(b_out_vld), 64'd0);
    tick();
    chk("t5_err_pulse", 64'(b_err), 64'd0);
    b_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_err_n", 64'(b_err), 64'd1);
      chk("t5_drop_n", 64'(b_drop), (i == 0) ? 64'd2 : 64'd3);
    end
    b_vld = 1'b0;
    tick();
    chk("t5_drop_sat", 64'(b_drop), 64'd3);
    chk("t5_a_drop", 64'(a_drop), 64'd0);

    // 6. async reset with two words held in ch0
    a_out_rdy = 4'b0000;
    a_sel = 2'd0; a_in = 39'hAA; a_vld = 1'b1;
    tick();
    a_in = 39'hBB;
    tick();
    a_vld = 1'b0;
    chk("t6_held", 64'(a_out_vld), 64'b0001);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_vld", 64'(a_out_vld), 64'd0);
    chk("t6_rst_out", 64'(a_ch(0)), 64'd0);
    chk("t6_rst_rdy", 64'(a_rdy), 64'd0);
    chk("t6_rst_bdrop", 64'(b_drop), 64'd0);
    #3 reset = 1'b0;
    a_out_rdy = 4'b1111;
    tick();
    a_sel = 2'd0; a_in = 39'h1; a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    chk("t6_vld", 64'(a_out_vld), 64'b0001);
    chk("t6_dat", 64'(a_ch(0)), 64'h1);
    tick();
    chk("t6_only_one", 64'(a_out_vld), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
